// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: FSM encoding,
// mode-register bit positions and the chip-select index width helper.
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_LEAD  = 2'd1;
  localparam state_t S_XFER  = 2'd2;
  localparam state_t S_TRAIL = 2'd3;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned MODE_CPOL = 0;
  localparam int unsigned MODE_CPHA = 1;

  // Chip-select index width: at least one bit even for a single line.
  function automatic int unsigned csw_of(input int unsigned ncs);
    return (ncs > 1) ? $clog2(ncs) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// DIV-cycle divider: counts while enabled and emits a one-cycle tick on the
// last count of each period, then wraps.
module spi_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick_c = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Parametrised SPI master with per-transfer CPOL/CPHA, CS setup/hold phases
// and a start/busy/done handshake; everything runs on the system clock.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter  int unsigned DW  = 8,
  parameter  int unsigned DIV = 4,
  parameter  int unsigned NCS = 1,
  localparam int unsigned CSW = csw_of(NCS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [DW-1:0]  MTX_DAT,
  input  logic [CSW-1:0] cs_sel,
  input  logic           cpol,
  input  logic           cpha,
  input  logic           MISO,
  output logic           MOSI,
  output logic           SCLK,
  output logic [NCS-1:0] cs_n,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  MRX_DAT
);

  localparam int unsigned EW = $clog2(2 * DW);

  state_t            state, state_d;
  logic [DW-1:0]     tx, tx_d;
  logic [DW-1:0]     rx, rx_d;
  logic [EW-1:0]     e_cnt, e_d;
  logic [MODE_W-1:0] mode, mode_d;
  logic [CSW-1:0]    sel, sel_d;
  logic              sclk_q, sclk_d;
  logic [NCS-1:0]    cs_n_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     mrx, mrx_d;
  logic              div_clr, div_en, tick;
  logic              odd_edge;

  spi_clk_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .en     (div_en),
    .tick_c (tick)
  );

  assign odd_edge = e_cnt[0];

  always_comb begin
    state_d = state;
    tx_d    = tx;
    rx_d    = rx;
    e_d     = e_cnt;
    mode_d  = mode;
    sel_d   = sel;
    sclk_d  = sclk_q;
    mrx_d   = mrx;
    done_d  = 1'b0;
    div_clr = 1'b0;
    div_en  = 1'b0;

    case (state)
      S_IDLE: begin
        sclk_d = cpol;
        tx_d   = '0;
        if (st) begin
          tx_d              = MTX_DAT;
          rx_d              = '0;
          e_d               = '0;
          mode_d[MODE_CPOL] = cpol;
          mode_d[MODE_CPHA] = cpha;
          sel_d             = cs_sel;
          div_clr           = 1'b1;
          state_d           = S_LEAD;
        end
      end
      S_LEAD: begin
        div_en = 1'b1;
        if (tick) state_d = S_XFER;
      end
      S_XFER: begin
        div_en = 1'b1;
        if (tick) begin
          sclk_d = ~sclk_q;
          e_d    = e_cnt + EW'(1);
          // CPHA=0 samples on even edges and shifts on odd ones; CPHA=1 is
          // the reverse, except edge 0 which only launches the MSB already out.
          if (mode[MODE_CPHA] ? odd_edge : !odd_edge)
            rx_d = {rx[DW-2:0], MISO};
          if (mode[MODE_CPHA] ? (!odd_edge && e_cnt != '0) : odd_edge)
            tx_d = {tx[DW-2:0], 1'b0};
          if (e_cnt == EW'(2 * DW - 1)) state_d = S_TRAIL;
        end
      end
      S_TRAIL: begin
        div_en = 1'b1;
        if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          mrx_d   = rx;
          tx_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An out-of-range select matches no line, so the transfer runs unselected.
    cs_d = '1;
    if (state_d != S_IDLE) begin
      for (int unsigned i = 0; i < NCS; i++) begin
        if (sel_d == CSW'(i)) cs_d[i] = 1'b0;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      tx     <= '0;
      rx     <= '0;
      e_cnt  <= '0;
      mode   <= '0;
      sel    <= '0;
      sclk_q <= 1'b0;
      cs_n_q <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mrx    <= '0;
    end else begin
      state  <= state_d;
      tx     <= tx_d;
      rx     <= rx_d;
      e_cnt  <= e_d;
      mode   <= mode_d;
      sel    <= sel_d;
      sclk_q <= sclk_d;
      cs_n_q <= cs_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mrx    <= mrx_d;
    end
  end

  assign MOSI    = tx[DW-1];
  assign SCLK    = sclk_q;
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign MRX_DAT = mrx;

endmodule
